// File: rtl/mmio_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter.
// Register offsets are word indices, i.e. DataAdr[3:2] within the window.
package mmio_pkg;
    localparam logic [1:0] TXDATA_OFS = 2'd0;
    localparam logic [1:0] STATUS_OFS = 2'd1;
    localparam logic [1:0] COUNT_OFS  = 2'd2;

    localparam int ST_BUSY  = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_EMPTY = 2;
    localparam int ST_OVF   = 3;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
endpackage

// File: rtl/mmio_uart_tx_if.sv
// Core data-memory port as seen by the UART register window.
// Handshake: MemWrite is a one-cycle store strobe with no ready/backpressure;
// ReadData and Sel are combinational on DataAdr and valid in the same cycle.
interface mmio_uart_tx_if;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Sel;

    modport master (output MemWrite, DataAdr, WriteData, input ReadData, Sel);
    modport slave  (input MemWrite, DataAdr, WriteData, output ReadData, Sel);
endinterface

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO; pushes to a full FIFO and pops from an empty one are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign wr_en = push & ~full;
    assign rd_en = pop & ~empty;
    assign dout  = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: address decode, register read mux,
// sticky overflow flag and the bit-serializer FSM draining a transmit FIFO.
module mmio_uart_tx
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
    parameter int          CLKS_PER_BIT = 4,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic           clk,
    input  logic           reset,
    mmio_uart_tx_if.slave  bus,
    output logic           tx,
    output uart_state_t    state
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    logic [1:0]    ofs;
    logic          sel;
    logic          push;
    logic          ovf_clr;
    logic          ovf;
    logic          pop;
    logic [7:0]    fifo_dout;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic [31:0]   status;
    logic [31:0]   rdata;

    uart_state_t   next_state;
    logic [BW-1:0] baud, next_baud;
    logic [2:0]    bit_idx, next_bit;
    logic [7:0]    shift, next_shift;
    logic          next_tx;
    logic          baud_last;

    logic          unused_bits;
    assign unused_bits = ^{bus.WriteData[31:8], bus.DataAdr[1:0]};

    assign ofs     = bus.DataAdr[3:2];
    assign sel     = (bus.DataAdr[31:4] == BASE_ADDR[31:4]) && (ofs != 2'b11);
    assign push    = bus.MemWrite & sel & (ofs == TXDATA_OFS);
    assign ovf_clr = bus.MemWrite & sel & (ofs == STATUS_OFS);
    assign bus.Sel = sel;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (bus.WriteData[7:0]),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        status           = '0;
        status[ST_BUSY]  = (state != IDLE);
        status[ST_FULL]  = full;
        status[ST_EMPTY] = empty;
        status[ST_OVF]   = ovf;
        rdata            = '0;
        if (sel) begin
            case (ofs)
                STATUS_OFS: rdata = status;
                COUNT_OFS:  rdata = 32'(count);
                default:    rdata = '0;
            endcase
        end
    end
    assign bus.ReadData = rdata;

    assign baud_last = (baud == BAUD_LAST);

    always_comb begin
        next_state = state;
        next_baud  = baud;
        next_bit   = bit_idx;
        next_shift = shift;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                next_baud = '0;
                if (!empty) begin
                    pop        = 1'b1;
                    next_shift = fifo_dout;
                    next_state = START;
                end
            end
            START: begin
                next_baud = baud + BW'(1);
                if (baud_last) begin
                    next_baud  = '0;
                    next_bit   = '0;
                    next_state = DATA;
                end
            end
            DATA: begin
                next_baud = baud + BW'(1);
                if (baud_last) begin
                    next_baud  = '0;
                    next_shift = shift >> 1;
                    if (bit_idx == 3'd7) next_state = STOP;
                    else                 next_bit   = bit_idx + 3'd1;
                end
            end
            STOP: begin
                next_baud = baud + BW'(1);
                if (baud_last) begin
                    next_baud = '0;
                    // Chain the next frame with no idle gap when data is waiting.
                    if (!empty) begin
                        pop        = 1'b1;
                        next_shift = fifo_dout;
                        next_state = START;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
        case (next_state)
            START:   next_tx = 1'b0;
            DATA:    next_tx = next_shift[0];
            default: next_tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
            ovf     <= 1'b0;
        end else begin
            state   <= next_state;
            baud    <= next_baud;
            bit_idx <= next_bit;
            shift   <= next_shift;
            tx      <= next_tx;
            if (push && full) ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CPB=4, DEPTH=4, BASE=0x100.
module tb_mmio_uart_tx;
    import mmio_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        tx;
    uart_state_t state;
    int          n_vec = 0;
    int          n_fail = 0;

    mmio_uart_tx_if bus ();

    mmio_uart_tx #(
        .BASE_ADDR    (32'h0000_0100),
        .CLKS_PER_BIT (4),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .tx    (tx),
        .state (state)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic read_reg(input logic [31:0] addr, output logic [31:0] data);
        bus.DataAdr = addr;
        #1;
        data = bus.ReadData;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.MemWrite  = 1'b1;
        bus.DataAdr   = addr;
        bus.WriteData = data;
        @(negedge clk);
        bus.MemWrite  = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic [31:0] addrs [5];
        logic        exp_sel [5];
        addrs   = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h060};
        exp_sel = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        bus.MemWrite = 1'b0; bus.DataAdr = '0; bus.WriteData = '0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_vec++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
        n_vec++;
        if (state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", state, IDLE); end
        read_reg(32'h104, rd);
        n_vec++;
        if (rd !== 32'h4) begin n_fail++; $display("FAIL reset_status: got %h want 00000004", rd); end
        read_reg(32'h108, rd);
        n_vec++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_count: got %h want 00000000", rd); end
        for (int i = 0; i < 5; i++) begin
            bus.DataAdr = addrs[i];
            #1;
            n_vec++;
            if (bus.Sel !== exp_sel[i]) begin
                n_fail++;
                $display("FAIL sel_decode addr %h: got %b want %b", addrs[i], bus.Sel, exp_sel[i]);
            end
        end
    endtask

    task automatic test_single_frame();
        logic [31:0] rd;
        logic [9:0]  frame;
        frame = {1'b1, 8'h55, 1'b0};
        bus_write(32'h100, 32'h55);
        read_reg(32'h104, rd);
        n_vec++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL single_status_after_push: got %h want 00000000", rd); end
        read_reg(32'h108, rd);
        n_vec++;
        if (rd !== 32'h1) begin n_fail++; $display("FAIL single_count_after_push: got %h want 00000001", rd); end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            n_vec++;
            if (tx !== frame[k/4]) begin
                n_fail++;
                $display("FAIL single_tx cycle %0d: got %b want %b", k, tx, frame[k/4]);
            end
            read_reg(32'h104, rd);
            n_vec++;
            if (rd[ST_BUSY] !== 1'b1) begin n_fail++; $display("FAIL single_busy cycle %0d: got %b want 1", k, rd[ST_BUSY]); end
            if (k == 0) begin
                read_reg(32'h108, rd);
                n_vec++;
                if (rd !== 32'h0) begin n_fail++; $display("FAIL single_count_after_pop: got %h want 00000000", rd); end
            end
        end
        @(negedge clk);
        read_reg(32'h104, rd);
        n_vec++;
        if (rd !== 32'h4) begin n_fail++; $display("FAIL single_status_done: got %h want 00000004", rd); end
        n_vec++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL single_tx_idle: got %b want 1", tx); end
    endtask

    task automatic test_overflow_back_to_back();
        logic [31:0] rd;
        logic        samples [200];
        logic [9:0]  frame;
        logic [7:0]  byte_v;
        @(negedge clk);
        bus.MemWrite = 1'b1; bus.DataAdr = 32'h100; bus.WriteData = 32'h11;
        for (int j = 0; j <= 200; j++) begin
            @(negedge clk);
            if (j >= 1) samples[j-1] = tx;
            if (j < 5) begin
                bus.WriteData = 32'h12 + 32'(j);
            end else if (j == 5) begin
                bus.MemWrite = 1'b0;
                read_reg(32'h104, rd);
                n_vec++;
                if (rd !== 32'hB) begin n_fail++; $display("FAIL ovf_status: got %h want 0000000b", rd); end
                read_reg(32'h108, rd);
                n_vec++;
                if (rd !== 32'h4) begin n_fail++; $display("FAIL ovf_count: got %h want 00000004", rd); end
            end
        end
        for (int k = 0; k < 200; k++) begin
            byte_v = 8'h11 + 8'(k / 40);
            frame  = {1'b1, byte_v, 1'b0};
            n_vec++;
            if (samples[k] !== frame[(k % 40) / 4]) begin
                n_fail++;
                $display("FAIL b2b_tx cycle %0d (byte %h): got %b want %b", k, byte_v, samples[k], frame[(k % 40) / 4]);
            end
        end
        @(negedge clk);
        read_reg(32'h104, rd);
        n_vec++;
        if (rd !== 32'hC) begin n_fail++; $display("FAIL b2b_status_done: got %h want 0000000c", rd); end
    endtask

    task automatic test_ovf_clear();
        logic [31:0] rd;
        bit          drained;
        for (int i = 0; i < 5; i++) bus_write(32'h100, 32'hA1 + 32'(i));
        read_reg(32'h104, rd);
        n_vec++;
        if (rd !== 32'hB) begin n_fail++; $display("FAIL clr_status_before: got %h want 0000000b", rd); end
        bus_write(32'h104, 32'hFFFF_FFFF);
        read_reg(32'h104, rd);
        n_vec++;
        if (rd !== 32'h3) begin n_fail++; $display("FAIL clr_status_after: got %h want 00000003", rd); end
        read_reg(32'h108, rd);
        n_vec++;
        if (rd !== 32'h4) begin n_fail++; $display("FAIL clr_count_kept: got %h want 00000004", rd); end
        drained = 1'b0;
        for (int i = 0; i < 400 && !drained; i++) begin
            @(negedge clk);
            read_reg(32'h104, rd);
            if (rd == 32'h4) drained = 1'b1;
        end
        n_vec++;
        if (rd !== 32'h4) begin n_fail++; $display("FAIL clr_drain: got %h want 00000004", rd); end
    endtask

    task automatic test_outside_window();
        logic [31:0] rd;
        @(negedge clk);
        bus.MemWrite = 1'b1; bus.DataAdr = 32'h060; bus.WriteData = 32'h3C;
        #1;
        n_vec++;
        if (bus.Sel !== 1'b0) begin n_fail++; $display("FAIL outside_sel: got %b want 0", bus.Sel); end
        n_vec++;
        if (bus.ReadData !== 32'h0) begin n_fail++; $display("FAIL outside_rdata: got %h want 00000000", bus.ReadData); end
        @(negedge clk);
        bus.MemWrite = 1'b0;
        read_reg(32'h108, rd);
        n_vec++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL outside_count: got %h want 00000000", rd); end
        read_reg(32'h104, rd);
        n_vec++;
        if (rd !== 32'h4) begin n_fail++; $display("FAIL outside_status: got %h want 00000004", rd); end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_vec++;
            if (tx !== 1'b1) begin n_fail++; $display("FAIL outside_tx cycle %0d: got %b want 1", k, tx); end
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd;
        bus_write(32'h100, 32'h81);
        bus_write(32'h100, 32'h82);
        bus_write(32'h100, 32'h83);
        repeat (9) @(negedge clk);
        n_vec++;
        if (tx !== 1'b0) begin n_fail++; $display("FAIL abort_tx_midframe: got %b want 0", tx); end
        read_reg(32'h108, rd);
        n_vec++;
        if (rd !== 32'h2) begin n_fail++; $display("FAIL abort_count_queued: got %h want 00000002", rd); end
        reset = 1'b0;
        #1;
        n_vec++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL abort_tx_async: got %b want 1", tx); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        read_reg(32'h104, rd);
        n_vec++;
        if (rd !== 32'h4) begin n_fail++; $display("FAIL abort_status: got %h want 00000004", rd); end
        read_reg(32'h108, rd);
        n_vec++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL abort_count: got %h want 00000000", rd); end
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            n_vec++;
            if (tx !== 1'b1) begin n_fail++; $display("FAIL abort_tx_quiet cycle %0d: got %b want 1", k, tx); end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_overflow_back_to_back();
        test_ovf_clear();
        test_outside_window();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
